// File: rtl/boot_run_sequencer.sv
// Host-side boot/run sequencer for the single-cycle RV32I core: preloads data
// memory from a small table, releases the core, snoops trace/done stores.
module boot_run_sequencer #(
    parameter int          DEPTH      = 8,
    parameter logic [31:0] TRACE_ADDR = 32'h0200_0008,
    parameter logic [31:0] DONE_ADDR  = 32'h0200_000C,
    parameter int          TIMEOUT    = 20000,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tbl_we,
    input  logic [31:0]      tbl_adr,
    input  logic [31:0]      tbl_data,
    input  logic             tbl_clr,
    input  logic             start,
    input  logic             MemWrite,
    input  logic [31:0]      DataAdr,
    input  logic [31:0]      WriteData,
    output logic             cpu_reset,
    output logic             Ext_MemWrite,
    output logic [31:0]      Ext_WriteData,
    output logic [31:0]      Ext_DataAdr,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             tbl_full,
    output logic             trace_valid,
    output logic [31:0]      trace_data,
    output logic [7:0]       trace_count,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = IW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_GAP,
        S_RUN,
        S_DONE,
        S_TOUT
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_idx;
    logic [CW-1:0]     w_idx_next;
    logic [CW-1:0]     r_count;
    logic [31:0]       r_tbl_adr  [DEPTH];
    logic [31:0]       r_tbl_data [DEPTH];
    logic              r_ext_we;
    logic [31:0]       r_ext_adr;
    logic [31:0]       r_ext_data;
    logic              r_done;
    logic              r_timeout;
    logic              r_trace_valid;
    logic [31:0]       r_trace_data;
    logic [7:0]        r_trace_count;
    logic [CNT_W-1:0]  r_cycle;

    logic w_idle_like;
    logic w_full;
    logic w_start;
    logic w_run;
    logic w_done_st;
    logic w_trace_st;
    logic w_tout;
    logic w_tbl_wr;

    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) ||
                         (r_state == S_TOUT);
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_start    = w_idle_like && start;
    assign w_run      = (r_state == S_RUN);
    assign w_done_st  = w_run && MemWrite && (DataAdr == DONE_ADDR) &&
                        (WriteData == 32'd1);
    assign w_trace_st = w_run && MemWrite && (DataAdr == TRACE_ADDR);
    assign w_tout     = w_run && !w_done_st &&
                        (r_cycle == CNT_W'(TIMEOUT - 1));
    assign w_tbl_wr   = w_idle_like && tbl_we && !tbl_clr && !w_full;

    always_comb begin
        w_next     = r_state;
        w_idx_next = r_idx;
        case (r_state)
            S_IDLE, S_DONE, S_TOUT: begin
                if (start) begin
                    w_idx_next = '0;
                    w_next     = (r_count != '0) ? S_LOAD : S_RUN;
                end
            end
            S_LOAD: w_next = S_GAP;
            S_GAP: begin
                w_idx_next = r_idx + CW'(1);
                w_next     = (w_idx_next < r_count) ? S_LOAD : S_RUN;
            end
            S_RUN: begin
                if (w_done_st) begin
                    w_next = S_DONE;
                end else if (w_tout) begin
                    w_next = S_TOUT;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_count       <= '0;
            r_ext_we      <= 1'b0;
            r_ext_adr     <= '0;
            r_ext_data    <= '0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_trace_valid <= 1'b0;
            r_trace_data  <= '0;
            r_trace_count <= '0;
            r_cycle       <= '0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_idx_next;

            // Ext_* are registered from the next state so they line up with LOAD.
            if (w_next == S_LOAD) begin
                r_ext_we   <= 1'b1;
                r_ext_adr  <= r_tbl_adr[w_idx_next[IW-1:0]];
                r_ext_data <= r_tbl_data[w_idx_next[IW-1:0]];
            end else begin
                r_ext_we   <= 1'b0;
                r_ext_adr  <= '0;
                r_ext_data <= '0;
            end

            if (w_idle_like && tbl_clr) begin
                r_count <= '0;
            end else if (w_tbl_wr) begin
                r_count <= r_count + CW'(1);
            end

            if (w_start) begin
                r_done <= 1'b0;
            end else if (w_done_st) begin
                r_done <= 1'b1;
            end

            if (w_start) begin
                r_timeout <= 1'b0;
            end else if (w_tout) begin
                r_timeout <= 1'b1;
            end

            r_trace_valid <= w_trace_st;
            if (w_trace_st) begin
                r_trace_data <= WriteData;
            end

            if (w_start) begin
                r_trace_count <= '0;
            end else if (w_trace_st && r_trace_count != 8'hFF) begin
                r_trace_count <= r_trace_count + 8'd1;
            end

            // Frozen on the exit cycle so it reads the index of the last RUN cycle.
            if (w_start) begin
                r_cycle <= '0;
            end else if (w_run && w_next == S_RUN) begin
                r_cycle <= r_cycle + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_tbl_wr) begin
            r_tbl_adr[r_count[IW-1:0]]  <= tbl_adr;
            r_tbl_data[r_count[IW-1:0]] <= tbl_data;
        end
    end

    assign cpu_reset     = (r_state != S_RUN);
    assign busy          = (r_state == S_LOAD) || (r_state == S_GAP) || w_run;
    assign tbl_full      = w_full;
    assign Ext_MemWrite  = r_ext_we;
    assign Ext_DataAdr   = r_ext_adr;
    assign Ext_WriteData = r_ext_data;
    assign done          = r_done;
    assign timeout       = r_timeout;
    assign trace_valid   = r_trace_valid;
    assign trace_data    = r_trace_data;
    assign trace_count   = r_trace_count;
    assign cycle_count   = r_cycle;

endmodule

// File: tb/tb_boot_run_sequencer.sv
// Self-checking bench for boot_run_sequencer: vector table, hand-written
// corner sequences and randomized runs against a behavioural model.
module tb_boot_run_sequencer;

    localparam logic [31:0] TA = 32'h0200_0008;
    localparam logic [31:0] DA = 32'h0200_000C;
    localparam int          TO = 50;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tbl_we = 1'b0;
    logic [31:0] tbl_adr = '0;
    logic [31:0] tbl_data = '0;
    logic        tbl_clr = 1'b0;
    logic        start = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic        cpu_reset, Ext_MemWrite, busy, done, timeout, tbl_full;
    logic        trace_valid;
    logic [31:0] Ext_WriteData, Ext_DataAdr, trace_data;
    logic [7:0]  trace_count;
    logic [15:0] cycle_count;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] qa[$];
    logic [31:0] qd[$];

    boot_run_sequencer #(
        .DEPTH(8), .TRACE_ADDR(TA), .DONE_ADDR(DA),
        .TIMEOUT(TO), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .tbl_we(tbl_we), .tbl_adr(tbl_adr),
        .tbl_data(tbl_data), .tbl_clr(tbl_clr), .start(start),
        .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .cpu_reset(cpu_reset), .Ext_MemWrite(Ext_MemWrite),
        .Ext_WriteData(Ext_WriteData), .Ext_DataAdr(Ext_DataAdr),
        .busy(busy), .done(done), .timeout(timeout), .tbl_full(tbl_full),
        .trace_valid(trace_valid), .trace_data(trace_data),
        .trace_count(trace_count), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic        mw;
        logic [31:0] adr;
        logic [31:0] wd;
        logic        tv;
        logic [31:0] td;
        int          tc;
        logic        dn;
        logic        rst;
    } vec_t;
    vec_t vt[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] a, input logic [31:0] d);
        tbl_we = 1'b1; tbl_adr = a; tbl_data = d;
        tick();
        tbl_we = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        MemWrite = 1'b1; DataAdr = a; WriteData = d;
        tick();
        MemWrite = 1'b0;
    endtask

    // Expected load pattern: entry k/2 on even cycles, zeros on odd ones.
    task automatic check_load();
        for (int k = 0; k < 2 * qa.size(); k++) begin
            chk("load_we", Ext_MemWrite, (k % 2 == 0));
            chk("load_adr", Ext_DataAdr, (k % 2 == 0) ? qa[k/2] : 32'h0);
            chk("load_data", Ext_WriteData, (k % 2 == 0) ? qd[k/2] : 32'h0);
            chk("load_cpurst", cpu_reset, 1);
            chk("load_busy", busy, 1);
            chk("load_tv", trace_valid, 0);
            MemWrite = 1'($urandom_range(0, 1));
            DataAdr = TA;
            WriteData = $urandom;
            tick();
        end
        MemWrite = 1'b0;
        chk("run_cpurst", cpu_reset, 0);
        chk("run_we", Ext_MemWrite, 0);
        chk("run_tv", trace_valid, 0);
        chk("run_busy", busy, 1);
        chk("run_cyc0", cycle_count, 0);
    endtask

    initial begin
        logic [31:0] exp_td;
        vt[0] = '{1'b1, TA, 32'd3, 1'b1, 32'd3, 1, 1'b0, 1'b0};
        vt[1] = '{1'b0, TA, 32'd8, 1'b0, 32'd3, 1, 1'b0, 1'b0};
        vt[2] = '{1'b1, TA, 32'd7, 1'b1, 32'd7, 2, 1'b0, 1'b0};
        vt[3] = '{1'b1, DA, 32'd2, 1'b0, 32'd7, 2, 1'b0, 1'b0};
        vt[4] = '{1'b1, TA, 32'd12, 1'b1, 32'd12, 3, 1'b0, 1'b0};
        vt[5] = '{1'b1, 32'h0200_0000, 32'd99, 1'b0, 32'd12, 3, 1'b0, 1'b0};
        vt[6] = '{1'b0, DA, 32'd1, 1'b0, 32'd12, 3, 1'b0, 1'b0};
        vt[7] = '{1'b1, DA, 32'd1, 1'b0, 32'd12, 3, 1'b1, 1'b1};
        vt[8] = '{1'b1, TA, 32'd55, 1'b0, 32'd12, 3, 1'b1, 1'b1};

        #3;
        chk("rst_cpurst", cpu_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tout", timeout, 0);
        chk("rst_full", tbl_full, 0);
        chk("rst_we", Ext_MemWrite, 0);
        chk("rst_tc", trace_count, 0);
        chk("rst_cyc", cycle_count, 0);
        tick();
        reset = 1'b0;
        tick();

        // Empty table: straight to RUN, tbl_we during RUN ignored, timeout.
        qa.delete(); qd.delete();
        go();
        check_load();
        for (int i = 1; i < TO; i++) begin
            tbl_we = (i == 1); tbl_adr = 32'h40; tbl_data = 32'h41;
            tick();
            tbl_we = 1'b0;
            chk("tout_early", timeout, 0);
            chk("tout_cyc", cycle_count, i);
        end
        tick();
        chk("tout_flag", timeout, 1);
        chk("tout_cyc_end", cycle_count, TO - 1);
        chk("tout_cpurst", cpu_reset, 1);
        chk("tout_busy", busy, 0);
        chk("tout_done", done, 0);
        go();
        check_load();
        chk("tout_clear", timeout, 0);
        store(DA, 32'd1);
        chk("done_flag", done, 1);
        chk("done_cpurst", cpu_reset, 1);

        // Preload of four entries, then the trace / done-filter vector table.
        qa = '{32'h0200_0000, 32'h0200_0004, 32'h0200_0008, 32'h0200_000C};
        qd = '{32'd5, 32'd9, 32'd0, 32'd0};
        foreach (qa[i]) add(qa[i], qd[i]);
        go();
        check_load();
        for (int i = 0; i < 9; i++) begin
            MemWrite = vt[i].mw; DataAdr = vt[i].adr; WriteData = vt[i].wd;
            tick();
            MemWrite = 1'b0;
            chk($sformatf("vec%0d_tv", i), trace_valid, vt[i].tv);
            chk($sformatf("vec%0d_td", i), trace_data, vt[i].td);
            chk($sformatf("vec%0d_tc", i), trace_count, vt[i].tc);
            chk($sformatf("vec%0d_done", i), done, vt[i].dn);
            chk($sformatf("vec%0d_cpurst", i), cpu_reset, vt[i].rst);
        end
        chk("vec_cyc", cycle_count, 7);

        // Table edges: fill, clr beats we, 9th write dropped.
        tbl_clr = 1'b1; tick(); tbl_clr = 1'b0;
        for (int i = 0; i < 8; i++) add(32'h100 + 4 * i, i);
        chk("fill8_full", tbl_full, 1);
        tbl_clr = 1'b1; tbl_we = 1'b1; tick();
        tbl_clr = 1'b0; tbl_we = 1'b0;
        chk("clr_wins", tbl_full, 0);
        qa.delete(); qd.delete();
        go();
        check_load();
        store(DA, 32'd1);
        qa.delete(); qd.delete();
        for (int i = 0; i < 9; i++) begin
            add(32'h200 + 4 * i, 3 * i + 1);
            if (i < 8) begin
                qa.push_back(32'h200 + 4 * i);
                qd.push_back(3 * i + 1);
            end
        end
        chk("fill9_full", tbl_full, 1);
        go();
        check_load();
        tick(); tick();

        // Asynchronous reset in the middle of RUN.
        reset = 1'b1;
        #1;
        chk("mid_cpurst", cpu_reset, 1);
        chk("mid_we", Ext_MemWrite, 0);
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_full", tbl_full, 0);
        chk("mid_cyc", cycle_count, 0);
        tick();
        reset = 1'b0;
        tick();

        // Randomized runs against the behavioural model.
        exp_td = 32'h0;
        for (int t = 0; t < 40; t++) begin
            int n, c, tc, op;
            logic tv, dn, to, ended;
            tbl_clr = 1'b1; tick(); tbl_clr = 1'b0;
            qa.delete(); qd.delete();
            n = $urandom_range(0, 9);
            for (int i = 0; i < n; i++) begin
                logic [31:0] a, d;
                a = $urandom; d = $urandom;
                add(a, d);
                if (qa.size() < 8) begin
                    qa.push_back(a);
                    qd.push_back(d);
                end
            end
            chk("rnd_full", tbl_full, (qa.size() == 8));
            go();
            check_load();
            c = 0; tc = 0; tv = 0; dn = 0; to = 0; ended = 0;
            while (!ended) begin
                chk("rnd_cpurst", cpu_reset, 0);
                chk("rnd_cyc", cycle_count, c);
                chk("rnd_tv", trace_valid, tv);
                chk("rnd_td", trace_data, exp_td);
                chk("rnd_tc", trace_count, tc);
                op = $urandom_range(0, 9);
                MemWrite = !(op <= 3 || op == 8);
                DataAdr = (op == 4 || op == 5) ? TA :
                          (op == 6 || op == 8) ? DA :
                          (op == 9) ? TA + 32'h10 : $urandom;
                WriteData = (op == 6) ? $urandom_range(0, 2) :
                            (op == 8) ? 32'd1 : $urandom;
                tv = MemWrite && DataAdr == TA;
                if (tv) begin
                    exp_td = WriteData;
                    if (tc < 255) tc++;
                end
                if (MemWrite && DataAdr == DA && WriteData == 32'd1) begin
                    ended = 1; dn = 1;
                end else if (c == TO - 1) begin
                    ended = 1; to = 1;
                end else begin
                    c++;
                end
                tick();
                MemWrite = 1'b0;
            end
            chk("rnd_done", done, dn);
            chk("rnd_tout", timeout, to);
            chk("rnd_cyc_end", cycle_count, c);
            chk("rnd_end_cpurst", cpu_reset, 1);
            chk("rnd_end_busy", busy, 0);
            chk("rnd_end_tv", trace_valid, tv);
            chk("rnd_end_td", trace_data, exp_td);
            chk("rnd_end_tc", trace_count, tc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
